ovl_fire_collector: RTL and testbench
=====================================

// Module: ovl_fire_collector
// PURPOSE
//  Consumer side of the OVL checker fire interface: samples fire bits from NUM_CHK
//  checkers each clock and turns every cycle with a fire into a record.
//  Records are buffered in a FIFO and drained by a valid/ready reader (debug host or
//  trace port). Also keeps a sticky per-checker status, a total fire count and an
//  overflow count. Sits beside the checker instances in the test harness.
// PARAMETERS
//  NUM_CHK    8   number of checker fire inputs
//  DEPTH      8   FIFO depth in records; power of two, >=2
//  CNT_WIDTH  16  width of fire_count and ovf_count
//  TS_WIDTH   32  timestamp width (used only with OVL_FIRE_TIMESTAMP_EN)
// PORTS
//  clk         in   1          sampling clock, rising edge
//  reset_n     in   1          synchronous, active-low reset
//  enable      in   1          1 = capture fires; 0 = fires ignored, FIFO still drains
//  clear       in   1          sync clear of FIFO, status and counters
//  fire_in     in   NUM_CHK    fire pulses, one bit per checker
//  rec_valid   out  1          FIFO head record is valid
//  rec_ready   in   1          reader accepts head when rec_valid && rec_ready
//  rec_vector  out  NUM_CHK    fire_in snapshot of the head record
//  rec_time    out  TS_WIDTH   timestamp of the head record
//  sticky      out  NUM_CHK    bit i set once checker i has fired since reset/clear
//  fire_count  out  CNT_WIDTH  records captured (incl. dropped), saturating
//  ovf_count   out  CNT_WIDTH  records dropped on full FIFO, saturating
//  full        out  1          FIFO holds DEPTH records
// BEHAVIOUR
//  - Reset (reset_n==0 at posedge): FIFO empty, rec_valid=0, rec_vector=0,
//    rec_time=0, sticky=0, fire_count=0, ovf_count=0, full=0, timestamp=0.
//  - clear==1 acts the same as reset, except the timestamp counter keeps running.
//    The cycle's fire_in and rec_ready are ignored.
//  - Capture event: enable && |fire_in at a posedge. It forms one record
//    {fire_in, ts}, where ts is the timestamp value in that cycle. Several bits set in
//    one cycle give one record.
//  - Latency: an event into an empty FIFO gives rec_valid=1 on the next cycle.
//    Output is not combinational from fire_in.
//  - Pop: rec_valid && rec_ready. The head advances at that posedge.
//    rec_vector and rec_time hold stable while rec_valid && !rec_ready.
//  - Push accepted when !full, or when full with a pop in the same cycle.
//    Simultaneous push+pop keeps the occupancy unchanged.
//  - Full without a pop: the record is dropped and ovf_count increments.
//    sticky and fire_count still update.
//  - Capture event: fire_count increments and sticky |= fire_in.
//  - Counters saturate at 2**CNT_WIDTH-1 and never wrap.
//  - Timestamp increments every cycle out of reset and wraps 2**TS_WIDTH-1 -> 0.
//  - Pointers are log2(DEPTH) bits plus a wrap bit. full = occupancy==DEPTH.
//  - enable==0: no capture and no counter or sticky change. The reader may keep popping.
//  - Reset or clear mid-drain drops pending records immediately. rec_valid is 0 the
//    next cycle.
// CONFIGURATION
//  OVL_FIRE_TIMESTAMP_EN defined: a TS_WIDTH free-running counter exists, each FIFO
//    entry stores the timestamp, and rec_time presents it.
//  OVL_FIRE_TIMESTAMP_EN undefined: no counter and no timestamp storage. rec_time is
//    tied to 0 and the port width is kept.
// TESTING
//  1 Reset then fire_in=8'h04 for 1 cycle, rec_ready=1 -> next cycle rec_valid=1 with
//    rec_vector=04, then popped. sticky=04, fire_count=1.
//  2 fire_in=8'h81 in one cycle -> exactly one record, rec_vector=81, fire_count=1,
//    sticky=81.
//  3 rec_ready=0, DEPTH=8, 10 consecutive fire cycles -> full=1, ovf_count=2,
//    fire_count=10. The drain then returns the first 8 records in order.
//  4 FIFO full, fire and rec_ready=1 in the same cycle -> record accepted,
//    ovf_count unchanged, full stays 1.
//  5 Timestamp build: fires 5 cycles apart -> rec_time differs by 5.
//    Non-timestamp build: rec_time==0 always.
//  6 clear with 3 records pending -> next cycle rec_valid=0 and all counters/sticky 0.
//    enable=0 with fires -> no change.

Source files
------------

// File: rtl/ovl_fire_collector.sv
// ovl_fire_collector: consumer side of the OVL checker fire interface.
// Each cycle in which any checker fires while capture is enabled becomes one
// record. Records queue in a DEPTH-entry FIFO and leave through a valid/ready
// reader port. The block also keeps sticky per-checker status, a saturating
// fire count and a saturating overflow count.
// Optional feature macro: OVL_FIRE_TIMESTAMP_EN adds a free-running timestamp
// that is stored with every record and presented on rec_time. Without the
// macro, rec_time is tied to zero and keeps its full width.
module ovl_fire_collector #(
    parameter int NUM_CHK   = 8,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 16,
    parameter int TS_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [NUM_CHK-1:0]   fire_in,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [NUM_CHK-1:0]   rec_vector,
    output logic [TS_WIDTH-1:0]  rec_time,
    output logic [NUM_CHK-1:0]   sticky,
    output logic [CNT_WIDTH-1:0] fire_count,
    output logic [CNT_WIDTH-1:0] ovf_count,
    output logic                 full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [NUM_CHK-1:0]   sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] fire_count_q, fire_count_d;
    logic [CNT_WIDTH-1:0] ovf_count_q, ovf_count_d;
    logic [NUM_CHK-1:0]   vec_mem_q [DEPTH];

    logic capture;
    logic empty;
    logic is_full;
    logic pop;
    logic push;
    logic drop;

`ifdef OVL_FIRE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] ts_mem_q [DEPTH];
`endif

    // Handshake decode: empty/full from the wrap bit, push accepted when a slot is free or freed this cycle.
    always_comb begin
        capture = enable && (|fire_in);
        empty   = (wr_ptr_q == rd_ptr_q);
        is_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop     = !empty && rec_ready;
        push    = capture && (!is_full || pop);
        drop    = capture && is_full && !pop;
    end

    // Next-state for pointers, sticky status and the saturating counters.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        sticky_d     = sticky_q;
        fire_count_d = fire_count_q;
        ovf_count_d  = ovf_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (capture) begin
            sticky_d = sticky_q | fire_in;
            if (fire_count_q != {CNT_WIDTH{1'b1}}) begin
                fire_count_d = fire_count_q + 1'b1;
            end
        end
        if (drop && (ovf_count_q != {CNT_WIDTH{1'b1}})) begin
            ovf_count_d = ovf_count_q + 1'b1;
        end
    end

    // State registers; clear behaves like reset so pending records vanish at once.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            sticky_q     <= '0;
            fire_count_q <= '0;
            ovf_count_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            sticky_q     <= sticky_d;
            fire_count_q <= fire_count_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    // Record storage; written only on an accepted push outside reset/clear.
    always_ff @(posedge clk) begin
        if (reset_n && !clear && push) begin
            vec_mem_q[wr_ptr_q[AW-1:0]] <= fire_in;
        end
    end

`ifdef OVL_FIRE_TIMESTAMP_EN
    // Free-running timestamp; only reset restarts it, clear leaves it running.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Timestamp storage alongside each record.
    always_ff @(posedge clk) begin
        if (reset_n && !clear && push) begin
            ts_mem_q[wr_ptr_q[AW-1:0]] <= ts_q;
        end
    end
`endif

    // Head presentation; fields read as zero while no record is pending.
    always_comb begin
        rec_valid  = !empty;
        rec_vector = empty ? '0 : vec_mem_q[rd_ptr_q[AW-1:0]];
`ifdef OVL_FIRE_TIMESTAMP_EN
        rec_time   = empty ? '0 : ts_mem_q[rd_ptr_q[AW-1:0]];
`else
        rec_time   = '0;
`endif
        sticky     = sticky_q;
        fire_count = fire_count_q;
        ovf_count  = ovf_count_q;
        full       = is_full;
    end

endmodule

// File: tb/tb_ovl_fire_collector.sv
// tb_ovl_fire_collector: directed self-checking bench for ovl_fire_collector
// with default parameters (NUM_CHK=8, DEPTH=8, CNT_WIDTH=16, TS_WIDTH=32).
// Timestamp expectations follow OVL_FIRE_TIMESTAMP_EN when it is defined.
module tb_ovl_fire_collector;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        clear;
    logic [7:0]  fire_in;
    logic        rec_valid;
    logic        rec_ready;
    logic [7:0]  rec_vector;
    logic [31:0] rec_time;
    logic [7:0]  sticky;
    logic [15:0] fire_count;
    logic [15:0] ovf_count;
    logic        full;

    int total = 0;
    int bad   = 0;

    ovl_fire_collector dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (clear),
        .fire_in    (fire_in),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_vector (rec_vector),
        .rec_time   (rec_time),
        .sticky     (sticky),
        .fire_count (fire_count),
        .ovf_count  (ovf_count),
        .full       (full)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One counted comparison.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hold reset for two edges, then release with inputs idle.
    task automatic doReset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        fire_in   = 8'h00;
        rec_ready = 1'b0;
        applyStimulus(2);
        reset_n = 1'b1;
        enable  = 1'b1;
    endtask

    logic [7:0]  drainExp [8];
    logic [31:0] tsA;
    logic [31:0] tsB;

    initial begin
        // Reset state
        doReset();
        checkOutput("reset_valid",  {31'd0, rec_valid}, 32'd0);
        checkOutput("reset_vector", {24'd0, rec_vector}, 32'd0);
        checkOutput("reset_time",   rec_time, 32'd0);
        checkOutput("reset_sticky", {24'd0, sticky}, 32'd0);
        checkOutput("reset_fcnt",   {16'd0, fire_count}, 32'd0);
        checkOutput("reset_ovf",    {16'd0, ovf_count}, 32'd0);
        checkOutput("reset_full",   {31'd0, full}, 32'd0);

        // Single fire, one-cycle latency, then popped
        rec_ready = 1'b1;
        fire_in   = 8'h04;
        applyStimulus(1);
        fire_in = 8'h00;
        checkOutput("t1_valid",  {31'd0, rec_valid}, 32'd1);
        checkOutput("t1_vector", {24'd0, rec_vector}, 32'h04);
        checkOutput("t1_sticky", {24'd0, sticky}, 32'h04);
        checkOutput("t1_fcnt",   {16'd0, fire_count}, 32'd1);
        applyStimulus(1);
        checkOutput("t1_popped", {31'd0, rec_valid}, 32'd0);

        // Multiple bits in one cycle give one record
        doReset();
        rec_ready = 1'b1;
        fire_in   = 8'h81;
        applyStimulus(1);
        fire_in = 8'h00;
        checkOutput("t2_vector", {24'd0, rec_vector}, 32'h81);
        checkOutput("t2_fcnt",   {16'd0, fire_count}, 32'd1);
        checkOutput("t2_sticky", {24'd0, sticky}, 32'h81);
        applyStimulus(1);
        checkOutput("t2_single", {31'd0, rec_valid}, 32'd0);
        checkOutput("t2_fcnt2",  {16'd0, fire_count}, 32'd1);

        // Ten fires into a stalled FIFO: vectors 1..10, last two dropped
        doReset();
        rec_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            fire_in = 8'(i);
            applyStimulus(1);
        end
        fire_in = 8'h00;
        checkOutput("t3_full",   {31'd0, full}, 32'd1);
        checkOutput("t3_ovf",    {16'd0, ovf_count}, 32'd2);
        checkOutput("t3_fcnt",   {16'd0, fire_count}, 32'd10);
        checkOutput("t3_sticky", {24'd0, sticky}, 32'h0F);
        applyStimulus(2);
        checkOutput("t3_hold",   {24'd0, rec_vector}, 32'h01);

        // Full with simultaneous fire and pop: accepted, no overflow
        fire_in   = 8'h40;
        rec_ready = 1'b1;
        applyStimulus(1);
        fire_in   = 8'h00;
        rec_ready = 1'b0;
        checkOutput("t4_full", {31'd0, full}, 32'd1);
        checkOutput("t4_ovf",  {16'd0, ovf_count}, 32'd2);
        checkOutput("t4_fcnt", {16'd0, fire_count}, 32'd11);

        // Drain: records 2..8 then the 0x40 record, in order
        drainExp[0] = 8'h02; drainExp[1] = 8'h03; drainExp[2] = 8'h04; drainExp[3] = 8'h05;
        drainExp[4] = 8'h06; drainExp[5] = 8'h07; drainExp[6] = 8'h08; drainExp[7] = 8'h40;
        rec_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("t3_drain%0d", k), {24'd0, rec_vector}, {24'd0, drainExp[k]});
            applyStimulus(1);
        end
        checkOutput("t3_empty", {31'd0, rec_valid}, 32'd0);
        checkOutput("t3_notfull", {31'd0, full}, 32'd0);

        // Timestamps: fires five cycles apart, starting right after reset
        doReset();
        rec_ready = 1'b0;
        fire_in   = 8'h01;
        applyStimulus(1);
        fire_in = 8'h00;
        applyStimulus(4);
        fire_in = 8'h02;
        applyStimulus(1);
        fire_in = 8'h00;
        tsA = rec_time;
        rec_ready = 1'b1;
        applyStimulus(1);
        rec_ready = 1'b0;
        tsB = rec_time;
        checkOutput("t5_vec2", {24'd0, rec_vector}, 32'h02);
`ifdef OVL_FIRE_TIMESTAMP_EN
        checkOutput("t5_timeA", tsA, 32'd0);
        checkOutput("t5_timeB", tsB, 32'd5);
`else
        checkOutput("t5_timeA", tsA, 32'd0);
        checkOutput("t5_timeB", tsB, 32'd0);
`endif

        // Clear with three records pending
        doReset();
        rec_ready = 1'b0;
        fire_in   = 8'h11;
        applyStimulus(3);
        checkOutput("t6_pending", {16'd0, fire_count}, 32'd3);
        clear     = 1'b1;
        fire_in   = 8'hFF;
        rec_ready = 1'b1;
        applyStimulus(1);
        clear     = 1'b0;
        fire_in   = 8'h00;
        rec_ready = 1'b0;
        checkOutput("t6_valid",  {31'd0, rec_valid}, 32'd0);
        checkOutput("t6_fcnt",   {16'd0, fire_count}, 32'd0);
        checkOutput("t6_ovf",    {16'd0, ovf_count}, 32'd0);
        checkOutput("t6_sticky", {24'd0, sticky}, 32'd0);
        checkOutput("t6_full",   {31'd0, full}, 32'd0);

        // Disabled capture ignores fires
        enable  = 1'b0;
        fire_in = 8'hFF;
        applyStimulus(2);
        fire_in = 8'h00;
        checkOutput("t6_dis_valid",  {31'd0, rec_valid}, 32'd0);
        checkOutput("t6_dis_fcnt",   {16'd0, fire_count}, 32'd0);
        checkOutput("t6_dis_sticky", {24'd0, sticky}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
